alu_cmd_sequencer: RTL and testbench
====================================

Name: alu_cmd_sequencer

Overview:
- Command-side driver for the Logic unit. It accepts ALU commands over a valid/ready handshake and reads operands from a 4-entry DATA_WIDTH-bit register file.
- It drives in_a/in_b/alu_opcode into the Logic unit, captures logic_out/logic_out_flag, writes results back, and returns a response over valid/ready.
- It sits between the instruction front end and the Logic unit instance. It is the initiator for the unit's operand/opcode interface.

Parameters:
- DATA_WIDTH, 8 (from CPU_package): operand/result width.
- RF_DEPTH, 4: register file entries; index width is $clog2(RF_DEPTH).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  sequencer can accept a command.
- cmd_opcode  input  enum_alu_opcode_t  operation.
- cmd_src_a  input  2  register index for operand A.
- cmd_src_b  input  2  register index for operand B.
- cmd_imm_sel  input  1  1 = operand B taken from cmd_imm.
- cmd_imm  input  DATA_WIDTH  immediate operand B.
- cmd_dst  input  2  writeback register index.
- wr_en  input  1  external register preload strobe.
- wr_addr  input  2  preload index.
- wr_data  input  DATA_WIDTH  preload data.
- alu_in_a  output  DATA_WIDTH  to Logic in_a.
- alu_in_b  output  DATA_WIDTH  to Logic in_b.
- alu_opcode  output  enum_alu_opcode_t  to Logic alu_opcode.
- alu_result  input  DATA_WIDTH  from Logic logic_out.
- alu_flag  input  3  from Logic logic_out_flag, {greater,equal,lower}.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer accepts response.
- rsp_data  output  DATA_WIDTH  captured result.
- rsp_flag  output  3  captured flags.

Behaviour:
- FSM states: IDLE, ISSUE, RESP. Reset state is IDLE.
- Reset values:
  - cmd_ready=1; rsp_valid=0.
  - rsp_data, rsp_flag, alu_in_a, alu_in_b = 0; alu_opcode = first enum literal.
  - All RF entries cleared to 0.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready, register opcode and dst. Register A=RF[src_a]; register B=cmd_imm_sel ? cmd_imm : RF[src_b]. Go to ISSUE.
- ISSUE:
  - cmd_ready=0. alu_in_a/alu_in_b/alu_opcode are driven from the registered values; they are stable from ISSUE until the next command.
  - At the end of the ISSUE cycle, capture alu_result→rsp_data and alu_flag→rsp_flag.
  - If opcode≠ALU_OP_CPR, write alu_result to RF[dst]. CPR writes no register.
  - Go to RESP.
- RESP:
  - rsp_valid=1. rsp_data/rsp_flag are held stable until the rsp_valid&rsp_ready handshake; then go to IDLE.
  - rsp_ready already high on entry completes the handshake in the first RESP cycle.
- Latency and throughput: command accept at cycle N → rsp_valid at cycle N+2. Minimum 3 cycles per command. No command pipelining.
- Operand hazard: read-after-write is always safe because writeback completes before the next accept.
- External preload:
  - wr_en is honoured only in IDLE. wr_en in ISSUE/RESP is ignored.
  - In IDLE, wr_en together with a command accept commits the write first. The operand read in that same cycle sees the new value (write-through bypass).
  - wr_en and a sequencer writeback never coincide, because writeback occurs only in ISSUE.
- Flags: rsp_flag is forwarded unmodified. It is 0 for every opcode except CPR (the Logic unit's behaviour). Opcodes outside the logic set produce rsp_data=0, rsp_flag=0 and a writeback of 0.
- Reset mid-operation (ISSUE or RESP): return to IDLE, drop any pending response (rsp_valid=0), clear RF.

Optional Feature:
- Macro ALU_SEQ_PERF_CNT_EN.
- When defined:
  - Adds output op_count (16 bits), reset to 0.
  - Increments by 1 on each rsp_valid&rsp_ready handshake and saturates at 0xFFFF.
  - Adds input op_count_clr (1 bit); op_count_clr=1 sets op_count to 0 the next cycle and takes priority over a simultaneous increment.
- When undefined: neither port exists and there is no counter logic.

Test Plan:
- Preload R0=0xF0, R1=0x3C; AND src_a=0 src_b=1 dst=2; rsp_ready=1 → rsp_valid 2 cycles after accept, rsp_data=0x30, rsp_flag=000, R2=0x30.
- OR R0,R1→R3, then XOR R3 with imm 0x0F→R3 → rsp_data=0xFC, then 0xF3; the second command reads the updated R3.
- CPR A=0x05 (R0), imm B=0x09 → rsp_flag=001, rsp_data=0, RF unchanged. Repeat with equal operands → 010; with A=0x09, B=0x05 → 100.
- NOTA on R0=0xF0 with rsp_ready held low 5 cycles → rsp_valid high and rsp_data=0x0F stable for all 5 cycles, cmd_ready=0 throughout; accepted on the cycle rsp_ready rises.
- Assert rst during ISSUE of an AND → next cycle rsp_valid=0, cmd_ready=1, all RF entries read 0; the following command completes normally.
- ALU_SEQ_PERF_CNT_EN defined: 3 completed commands → op_count=3; pulse op_count_clr on the same cycle as a 4th handshake → op_count=0.

Source files
------------

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: the command-side driver for the Logic unit.
//   It accepts an ALU command over valid/ready and reads its operands from a
//   small register file. It then drives the Logic unit for one ISSUE cycle,
//   writes the result back to the register file, and returns the captured
//   result and flags over valid/ready.
//   Schedule: accept at cycle N, ISSUE at N+1, rsp_valid at N+2.
//   Commands are never pipelined. Each command takes at least 3 cycles.
// Optional feature: define ALU_SEQ_PERF_CNT_EN to add the op_count_clr input
//   and op_count, a 16-bit saturating count of completed responses.

package CPU_package;
  localparam int DATA_WIDTH = 8;

  // The logic set runs from AND to CPR. The Logic unit answers the
  // arithmetic codes with a zero result and zero flags.
  typedef enum logic [3:0] {
    ALU_OP_AND  = 4'd0,
    ALU_OP_OR   = 4'd1,
    ALU_OP_XOR  = 4'd2,
    ALU_OP_NAND = 4'd3,
    ALU_OP_NOR  = 4'd4,
    ALU_OP_XNOR = 4'd5,
    ALU_OP_NOTA = 4'd6,
    ALU_OP_NOTB = 4'd7,
    ALU_OP_CPR  = 4'd8,
    ALU_OP_ADD  = 4'd9,
    ALU_OP_SUB  = 4'd10,
    ALU_OP_INC  = 4'd11,
    ALU_OP_DEC  = 4'd12
  } enum_alu_opcode_t;
endpackage

module alu_cmd_sequencer #(
  parameter  int DATA_WIDTH = CPU_package::DATA_WIDTH,
  parameter  int RF_DEPTH   = 4,
  localparam int IDX_W      = $clog2(RF_DEPTH)
) (
  input  logic                          clk,
  input  logic                          rst,
  // command channel
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  CPU_package::enum_alu_opcode_t cmd_opcode,
  input  logic [IDX_W-1:0]              cmd_src_a,
  input  logic [IDX_W-1:0]              cmd_src_b,
  input  logic                          cmd_imm_sel,
  input  logic [DATA_WIDTH-1:0]         cmd_imm,
  input  logic [IDX_W-1:0]              cmd_dst,
  // external register preload
  input  logic                          wr_en,
  input  logic [IDX_W-1:0]              wr_addr,
  input  logic [DATA_WIDTH-1:0]         wr_data,
  // Logic unit operand/opcode interface
  output logic [DATA_WIDTH-1:0]         alu_in_a,
  output logic [DATA_WIDTH-1:0]         alu_in_b,
  output CPU_package::enum_alu_opcode_t alu_opcode,
  input  logic [DATA_WIDTH-1:0]         alu_result,
  input  logic [2:0]                    alu_flag,
  // response channel
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
`ifdef ALU_SEQ_PERF_CNT_EN
  input  logic                          op_count_clr,
  output logic [15:0]                   op_count,
`endif
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic [2:0]                    rsp_flag
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  state_t                        r_state;
  logic                          r_cmd_ready;
  logic                          r_rsp_valid;
  logic [DATA_WIDTH-1:0]         r_rsp_data;
  logic [2:0]                    r_rsp_flag;
  logic [DATA_WIDTH-1:0]         r_alu_a;
  logic [DATA_WIDTH-1:0]         r_alu_b;
  CPU_package::enum_alu_opcode_t r_alu_op;
  logic [IDX_W-1:0]              r_dst;
  logic [DATA_WIDTH-1:0]         r_rf [RF_DEPTH];

  logic                          w_accept;
  logic                          w_rsp_hs;
  logic                          w_preload;
  logic                          w_writeback;
  logic [DATA_WIDTH-1:0]         w_opnd_a;
  logic [DATA_WIDTH-1:0]         w_opnd_b;

  // A preload is honoured only while idle. Writeback happens only in ISSUE,
  // so the two register-file write ports can never collide.
  assign w_preload   = wr_en && (r_state == ST_IDLE);
  assign w_accept    = cmd_valid && r_cmd_ready;
  assign w_rsp_hs    = r_rsp_valid && rsp_ready;
  assign w_writeback = (r_state == ST_ISSUE) &&
                       (r_alu_op != CPU_package::ALU_OP_CPR);

  // Operand selection. A preload in the accept cycle is forwarded to the read.
  always_comb begin
    // NOTE: give every combinational output a default before any branch so no path can leave it unassigned and infer a latch.
    w_opnd_a = r_rf[cmd_src_a];
    w_opnd_b = r_rf[cmd_src_b];
    if (w_preload && (wr_addr == cmd_src_a)) w_opnd_a = wr_data;
    if (w_preload && (wr_addr == cmd_src_b)) w_opnd_b = wr_data;
    if (cmd_imm_sel)                         w_opnd_b = cmd_imm;
  end

  // Register file: cleared by reset, preloaded in IDLE, written back in ISSUE.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the register file must read zero after reset, so it is built as resettable flops rather than an inferred RAM, which could not be cleared in one cycle.
      for (int i = 0; i < RF_DEPTH; i++) r_rf[i] <= '0;
    end else if (w_writeback) begin
      r_rf[r_dst] <= alu_result;
    end else if (w_preload) begin
      r_rf[wr_addr] <= wr_data;
    end
  end

  // Control FSM. It owns every registered handshake, operand and response output.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values regardless of statement order.
      r_state     <= ST_IDLE;
      r_cmd_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_flag  <= '0;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_op    <= CPU_package::ALU_OP_AND;
      r_dst       <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_alu_a     <= w_opnd_a;
            r_alu_b     <= w_opnd_b;
            r_alu_op    <= cmd_opcode;
            r_dst       <= cmd_dst;
            r_cmd_ready <= 1'b0;
            r_state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          // The Logic unit is combinational. Its answer is valid at the end of this cycle.
          r_rsp_data  <= alu_result;
          r_rsp_flag  <= alu_flag;
          r_rsp_valid <= 1'b1;
          r_state     <= ST_RESP;
        end
        ST_RESP: begin
          if (w_rsp_hs) begin
            r_rsp_valid <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_rsp_valid <= 1'b0;
          r_cmd_ready <= 1'b1;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready  = r_cmd_ready;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_data   = r_rsp_data;
  assign rsp_flag   = r_rsp_flag;
  assign alu_in_a   = r_alu_a;
  assign alu_in_b   = r_alu_b;
  assign alu_opcode = r_alu_op;

`ifdef ALU_SEQ_PERF_CNT_EN
  logic [15:0] r_op_count;

  // Completed-response counter. A clear beats a simultaneous increment, and the count saturates.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op_count <= '0;
    end else if (op_count_clr) begin
      r_op_count <= '0;
    end else if (w_rsp_hs && (r_op_count != 16'hFFFF)) begin
      r_op_count <= r_op_count + 16'd1;
    end
  end

  assign op_count = r_op_count;
`endif

  // Handshake invariants.
  a_ready_excl : assert property (@(posedge clk) disable iff (rst)
    !(r_rsp_valid && r_cmd_ready));
  a_rsp_hold : assert property (@(posedge clk) disable iff (rst)
    (r_rsp_valid && !rsp_ready) |=> (r_rsp_valid && $stable(r_rsp_data) && $stable(r_rsp_flag)));
  a_issue_to_resp : assert property (@(posedge clk) disable iff (rst)
    (r_state == ST_ISSUE) |=> r_rsp_valid);

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Testbench for alu_cmd_sequencer.
//   The bench supplies a behavioural stand-in for the Logic unit. It applies a
//   hand-derived vector table, then randomized commands predicted by a
//   register-file model. It also runs hand sequences for mid-operation reset
//   and, when ALU_SEQ_PERF_CNT_EN is defined, for the counter.
`timescale 1ns/1ps

module tb_alu_cmd_sequencer;
  import CPU_package::*;

  localparam int DW = CPU_package::DATA_WIDTH;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid, cmd_ready, cmd_imm_sel;
  enum_alu_opcode_t cmd_opcode, alu_opcode;
  logic [1:0]       cmd_src_a, cmd_src_b, cmd_dst, wr_addr;
  logic [DW-1:0]    cmd_imm, wr_data, alu_in_a, alu_in_b, alu_result, rsp_data;
  logic             wr_en, rsp_valid, rsp_ready;
  logic [2:0]       alu_flag, rsp_flag;
`ifdef ALU_SEQ_PERF_CNT_EN
  logic             op_count_clr;
  logic [15:0]      op_count;
`endif

  alu_cmd_sequencer dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
    .cmd_src_a(cmd_src_a), .cmd_src_b(cmd_src_b), .cmd_imm_sel(cmd_imm_sel),
    .cmd_imm(cmd_imm), .cmd_dst(cmd_dst),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .alu_in_a(alu_in_a), .alu_in_b(alu_in_b), .alu_opcode(alu_opcode),
    .alu_result(alu_result), .alu_flag(alu_flag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
`ifdef ALU_SEQ_PERF_CNT_EN
    .op_count_clr(op_count_clr), .op_count(op_count),
`endif
    .rsp_data(rsp_data), .rsp_flag(rsp_flag)
  );

  always #5 clk = ~clk;

  // Logic unit behaviour: returns {flag[2:0], result}.
  function automatic logic [DW+2:0] logic_unit(input enum_alu_opcode_t op,
                                               input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW-1:0] d;
    logic [2:0]    f;
    d = '0;
    f = '0;
    case (op)
      ALU_OP_AND:  d = a & b;
      ALU_OP_OR:   d = a | b;
      ALU_OP_XOR:  d = a ^ b;
      ALU_OP_NAND: d = ~(a & b);
      ALU_OP_NOR:  d = ~(a | b);
      ALU_OP_XNOR: d = ~(a ^ b);
      ALU_OP_NOTA: d = ~a;
      ALU_OP_NOTB: d = ~b;
      ALU_OP_CPR:  f = (a > b) ? 3'b100 : ((a == b) ? 3'b010 : 3'b001);
      default:     ;
    endcase
    return {f, d};
  endfunction

  always_comb {alu_flag, alu_result} = logic_unit(alu_opcode, alu_in_a, alu_in_b);

  typedef struct {
    enum_alu_opcode_t op;
    logic [1:0]       sa, sb;
    logic             imm_sel;
    logic [DW-1:0]    imm;
    logic [1:0]       dst;
    logic             pre_en;
    logic [1:0]       pre_addr;
    logic [DW-1:0]    pre_data;
    int               rsp_delay;
  } cmd_t;

  typedef struct {
    cmd_t          c;
    logic [DW-1:0] ea, eb, ed;
    logic [2:0]    ef;
  } vec_t;

  int            checks   = 0;
  int            failures = 0;
  logic [DW-1:0] m_rf [4];
  int            m_count;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic cmd_t mk_cmd(input enum_alu_opcode_t op, input logic [1:0] sa, input logic [1:0] sb,
                                  input logic imm_sel, input logic [DW-1:0] imm, input logic [1:0] dst,
                                  input logic pre_en, input logic [1:0] pre_addr,
                                  input logic [DW-1:0] pre_data, input int rsp_delay);
    cmd_t c;
    c.op = op; c.sa = sa; c.sb = sb; c.imm_sel = imm_sel; c.imm = imm; c.dst = dst;
    c.pre_en = pre_en; c.pre_addr = pre_addr; c.pre_data = pre_data; c.rsp_delay = rsp_delay;
    return c;
  endfunction

  function automatic vec_t mk_vec(input cmd_t c, input logic [DW-1:0] ea, input logic [DW-1:0] eb,
                                  input logic [DW-1:0] ed, input logic [2:0] ef);
    vec_t v;
    v.c = c; v.ea = ea; v.eb = eb; v.ed = ed; v.ef = ef;
    return v;
  endfunction

  // Reference prediction: apply any same-cycle preload, read operands, evaluate.
  task automatic predict(input cmd_t c, output logic [DW-1:0] a, output logic [DW-1:0] b,
                         output logic [DW-1:0] d, output logic [2:0] f);
    logic [DW-1:0] rf [4];
    logic [DW+2:0] r;
    rf = m_rf;
    if (c.pre_en) rf[c.pre_addr] = c.pre_data;
    a = rf[c.sa];
    b = c.imm_sel ? c.imm : rf[c.sb];
    r = logic_unit(c.op, a, b);
    d = r[DW-1:0];
    f = r[DW+2:DW];
  endtask

  task automatic clear_model();
    for (int i = 0; i < 4; i++) m_rf[i] = '0;
    m_count = 0;
  endtask

  // Runs one command from an idle negedge to the negedge after its response handshake.
  task automatic run_cmd(input cmd_t c, input logic [DW-1:0] ea, input logic [DW-1:0] eb,
                         input logic [DW-1:0] ed, input logic [2:0] ef,
                         input bit noise, input bit clr_hs, input string tag);
    int n = 0;
    while (cmd_ready !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check({tag, " cmd_ready@accept"}, 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_opcode = c.op; cmd_src_a = c.sa; cmd_src_b = c.sb;
    cmd_imm_sel = c.imm_sel; cmd_imm = c.imm; cmd_dst = c.dst;
    wr_en = c.pre_en; wr_addr = c.pre_addr; wr_data = c.pre_data;
    rsp_ready = (c.rsp_delay == 0);
    if (c.pre_en) m_rf[c.pre_addr] = c.pre_data;
    @(negedge clk);  // ISSUE
    cmd_valid = 1'b0; wr_en = 1'b0;
    cmd_src_a = 2'($urandom); cmd_src_b = 2'($urandom); cmd_imm = DW'($urandom);
    check({tag, " issue rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, " issue cmd_ready"}, 32'(cmd_ready), 32'd0);
    check({tag, " alu_in_a"}, 32'(alu_in_a), 32'(ea));
    check({tag, " alu_in_b"}, 32'(alu_in_b), 32'(eb));
    check({tag, " alu_opcode"}, 32'(alu_opcode), 32'(c.op));
    if (noise) begin
      wr_en = 1'b1; wr_addr = 2'($urandom); wr_data = DW'($urandom);
    end
    @(negedge clk);  // first RESP cycle
    check({tag, " rsp_valid"}, 32'(rsp_valid), 32'd1);
    check({tag, " rsp_data"}, 32'(rsp_data), 32'(ed));
    check({tag, " rsp_flag"}, 32'(rsp_flag), 32'(ef));
    for (int i = 0; i < c.rsp_delay; i++) begin
      @(negedge clk);
      check($sformatf("%s hold%0d rsp_valid", tag, i), 32'(rsp_valid), 32'd1);
      check($sformatf("%s hold%0d rsp_data", tag, i), 32'(rsp_data), 32'(ed));
      check($sformatf("%s hold%0d rsp_flag", tag, i), 32'(rsp_flag), 32'(ef));
      check($sformatf("%s hold%0d cmd_ready", tag, i), 32'(cmd_ready), 32'd0);
      check($sformatf("%s hold%0d alu_in_a", tag, i), 32'(alu_in_a), 32'(ea));
    end
    rsp_ready = 1'b1;
`ifdef ALU_SEQ_PERF_CNT_EN
    op_count_clr = clr_hs;
`endif
    @(negedge clk);  // back in IDLE
    rsp_ready = 1'b0; wr_en = 1'b0;
`ifdef ALU_SEQ_PERF_CNT_EN
    op_count_clr = 1'b0;
`endif
    check({tag, " post rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, " post cmd_ready"}, 32'(cmd_ready), 32'd1);
    if (c.op != ALU_OP_CPR) m_rf[c.dst] = ed;
    if (clr_hs) m_count = 0;
    else if (m_count < 16'hFFFF) m_count++;
`ifdef ALU_SEQ_PERF_CNT_EN
    check({tag, " op_count"}, 32'(op_count), 32'(m_count));
`endif
  endtask

  // Reads a register through a CPR, which writes nothing back.
  task automatic peek(input logic [1:0] idx, input logic [DW-1:0] exp, input string tag);
    cmd_t c;
    c = mk_cmd(ALU_OP_CPR, idx, 2'd0, 1'b1, '0, 2'd0, 1'b0, 2'd0, '0, 0);
    run_cmd(c, exp, '0, '0, (exp != '0) ? 3'b100 : 3'b010, 1'b0, 1'b0, tag);
  endtask

  task automatic preload(input logic [1:0] addr, input logic [DW-1:0] data);
    wr_en = 1'b1; wr_addr = addr; wr_data = data;
    m_rf[addr] = data;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; cmd_valid = 1'b0; wr_en = 1'b0; rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clear_model();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t          tbl [14];
    cmd_t          c;
    logic [DW-1:0] a, b, d;
    logic [2:0]    f;

    tbl[0]  = mk_vec(mk_cmd(ALU_OP_AND,  2'd0, 2'd1, 1'b0, 8'h00, 2'd2, 1'b0, 2'd0, 8'h00, 0), 8'hF0, 8'h3C, 8'h30, 3'b000);
    tbl[1]  = mk_vec(mk_cmd(ALU_OP_OR,   2'd0, 2'd1, 1'b0, 8'h00, 2'd3, 1'b0, 2'd0, 8'h00, 0), 8'hF0, 8'h3C, 8'hFC, 3'b000);
    tbl[2]  = mk_vec(mk_cmd(ALU_OP_XOR,  2'd3, 2'd0, 1'b1, 8'h0F, 2'd3, 1'b0, 2'd0, 8'h00, 1), 8'hFC, 8'h0F, 8'hF3, 3'b000);
    tbl[3]  = mk_vec(mk_cmd(ALU_OP_OR,   2'd2, 2'd0, 1'b1, 8'h00, 2'd1, 1'b0, 2'd0, 8'h00, 0), 8'h30, 8'h00, 8'h30, 3'b000);
    tbl[4]  = mk_vec(mk_cmd(ALU_OP_CPR,  2'd0, 2'd0, 1'b1, 8'h09, 2'd2, 1'b1, 2'd0, 8'h05, 0), 8'h05, 8'h09, 8'h00, 3'b001);
    tbl[5]  = mk_vec(mk_cmd(ALU_OP_CPR,  2'd0, 2'd0, 1'b1, 8'h05, 2'd2, 1'b0, 2'd0, 8'h00, 2), 8'h05, 8'h05, 8'h00, 3'b010);
    tbl[6]  = mk_vec(mk_cmd(ALU_OP_CPR,  2'd1, 2'd0, 1'b1, 8'h05, 2'd0, 1'b1, 2'd1, 8'h09, 0), 8'h09, 8'h05, 8'h00, 3'b100);
    tbl[7]  = mk_vec(mk_cmd(ALU_OP_OR,   2'd2, 2'd0, 1'b1, 8'h00, 2'd3, 1'b0, 2'd0, 8'h00, 0), 8'h30, 8'h00, 8'h30, 3'b000);
    tbl[8]  = mk_vec(mk_cmd(ALU_OP_NOTA, 2'd0, 2'd1, 1'b0, 8'h00, 2'd2, 1'b1, 2'd0, 8'hF0, 5), 8'hF0, 8'h09, 8'h0F, 3'b000);
    tbl[9]  = mk_vec(mk_cmd(ALU_OP_ADD,  2'd0, 2'd1, 1'b0, 8'h00, 2'd3, 1'b0, 2'd0, 8'h00, 0), 8'hF0, 8'h09, 8'h00, 3'b000);
    tbl[10] = mk_vec(mk_cmd(ALU_OP_OR,   2'd3, 2'd0, 1'b1, 8'h00, 2'd1, 1'b0, 2'd0, 8'h00, 0), 8'h00, 8'h00, 8'h00, 3'b000);
    tbl[11] = mk_vec(mk_cmd(ALU_OP_NAND, 2'd2, 2'd2, 1'b0, 8'h00, 2'd0, 1'b1, 2'd2, 8'hAA, 0), 8'hAA, 8'hAA, 8'h55, 3'b000);
    tbl[12] = mk_vec(mk_cmd(ALU_OP_XNOR, 2'd0, 2'd3, 1'b0, 8'h00, 2'd1, 1'b0, 2'd0, 8'h00, 1), 8'h55, 8'h00, 8'hAA, 3'b000);
    tbl[13] = mk_vec(mk_cmd(ALU_OP_NOTB, 2'd1, 2'd0, 1'b1, 8'h3C, 2'd2, 1'b0, 2'd0, 8'h00, 0), 8'hAA, 8'h3C, 8'hC3, 3'b000);

    rst = 1'b1; cmd_valid = 1'b0; cmd_opcode = ALU_OP_AND; cmd_src_a = '0; cmd_src_b = '0;
    cmd_imm_sel = 1'b0; cmd_imm = '0; cmd_dst = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rsp_ready = 1'b0;
`ifdef ALU_SEQ_PERF_CNT_EN
    op_count_clr = 1'b0;
`endif
    clear_model();
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state.
    check("reset cmd_ready", 32'(cmd_ready), 32'd1);
    check("reset rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset rsp_data", 32'(rsp_data), 32'd0);
    check("reset rsp_flag", 32'(rsp_flag), 32'd0);
    check("reset alu_in_a", 32'(alu_in_a), 32'd0);
    check("reset alu_in_b", 32'(alu_in_b), 32'd0);
    check("reset alu_opcode", 32'(alu_opcode), 32'(ALU_OP_AND));
`ifdef ALU_SEQ_PERF_CNT_EN
    check("reset op_count", 32'(op_count), 32'd0);
`endif

    // Directed vector table.
    preload(2'd0, 8'hF0);
    preload(2'd1, 8'h3C);
    for (int i = 0; i < 14; i++)
      run_cmd(tbl[i].c, tbl[i].ea, tbl[i].eb, tbl[i].ed, tbl[i].ef, 1'b0, 1'b0, $sformatf("vec%0d", i));

    // Randomized commands against the register-file model.
    for (int n = 0; n < 150; n++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        if ($urandom_range(0, 1) == 1) preload(2'($urandom), DW'($urandom));
        else @(negedge clk);
      end
      c = mk_cmd(enum_alu_opcode_t'(4'($urandom_range(0, 12))), 2'($urandom), 2'($urandom),
                 1'($urandom), DW'($urandom), 2'($urandom),
                 ($urandom_range(0, 2) == 0), 2'($urandom), DW'($urandom), $urandom_range(0, 3));
      predict(c, a, b, d, f);
      run_cmd(c, a, b, d, f, 1'($urandom), 1'b0, $sformatf("rnd%0d", n));
    end

    // Reset during ISSUE drops the command and clears the register file.
    preload(2'd0, 8'hF0);
    preload(2'd1, 8'h3C);
    cmd_valid = 1'b1; cmd_opcode = ALU_OP_AND; cmd_src_a = 2'd0; cmd_src_b = 2'd1;
    cmd_imm_sel = 1'b0; cmd_dst = 2'd2; rsp_ready = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("rstissue in issue", 32'(cmd_ready), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; rsp_ready = 1'b0;
    clear_model();
    check("rstissue rsp_valid", 32'(rsp_valid), 32'd0);
    check("rstissue cmd_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    check("rstissue rsp_valid later", 32'(rsp_valid), 32'd0);
    for (int i = 0; i < 4; i++) peek(2'(i), '0, $sformatf("rstissue peek%0d", i));
    preload(2'd0, 8'hF0);
    preload(2'd1, 8'h3C);
    run_cmd(mk_cmd(ALU_OP_AND, 2'd0, 2'd1, 1'b0, '0, 2'd2, 1'b0, 2'd0, '0, 0),
            8'hF0, 8'h3C, 8'h30, 3'b000, 1'b0, 1'b0, "after rst AND");
    peek(2'd2, 8'h30, "after rst R2");

    // Reset while a response is stalled.
    cmd_valid = 1'b1; cmd_opcode = ALU_OP_OR; cmd_src_a = 2'd0; cmd_src_b = 2'd1;
    cmd_imm_sel = 1'b0; cmd_dst = 2'd3; rsp_ready = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    check("rstresp pending", 32'(rsp_valid), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    clear_model();
    check("rstresp rsp_valid", 32'(rsp_valid), 32'd0);
    check("rstresp cmd_ready", 32'(cmd_ready), 32'd1);
    check("rstresp rsp_data", 32'(rsp_data), 32'd0);
    peek(2'd0, '0, "rstresp peek0");

`ifdef ALU_SEQ_PERF_CNT_EN
    // Counter: three handshakes, then a clear that coincides with the fourth.
    do_reset();
    for (int i = 0; i < 3; i++) peek(2'(i), '0, $sformatf("cnt peek%0d", i));
    check("op_count after 3", 32'(op_count), 32'd3);
    c = mk_cmd(ALU_OP_CPR, 2'd3, 2'd0, 1'b1, '0, 2'd0, 1'b0, 2'd0, '0, 1);
    run_cmd(c, '0, '0, '0, 3'b010, 1'b0, 1'b1, "cnt clr@hs");
    check("op_count clr beats inc", 32'(op_count), 32'd0);
    peek(2'd0, '0, "cnt one more");
    op_count_clr = 1'b1;
    @(negedge clk);
    op_count_clr = 1'b0;
    m_count = 0;
    check("op_count idle clr", 32'(op_count), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
